// File: rtl/interleaver_ctrl.sv
// rtl/interleaver_ctrl.sv - 802.11a interleaver buffer sequencer
// Writes serial coded bits at doubly-permuted addresses, drains 48 subcarrier groups, then clears.
module interleaver_ctrl #(
  parameter int NSC    = 48,
  parameter int ADDR_W = 9
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [2:0]        cfg_bpsc,
  input  logic              in_valid,
  input  logic              in_bit,
  output logic              in_ready,
  output logic              ib_wr_en,
  output logic [ADDR_W-1:0] ib_wr_addr,
  output logic              ib_data_in,
  output logic              ib_rd_en,
  output logic [5:0]        ib_rd_addr,
  output logic [8:0]        ib_cap,
  output logic [2:0]        ib_bpsc,
  output logic              ib_clear,
  input  logic              ib_full,
  input  logic [5:0]        ib_data_out,
  output logic              out_valid,
  output logic [5:0]        out_data,
  output logic              out_last,
  input  logic              out_ready,
  output logic              cfg_err
);
  localparam logic [1:0] FILL  = 2'd0;
  localparam logic [1:0] DRAIN = 2'd1;
  localparam logic [1:0] CLR   = 2'd2;
  localparam logic [5:0] NSC6  = 6'(NSC);

  logic [1:0] state;
  logic [8:0] wr_cnt;
  logic [5:0] rd_cnt, grp_idx;
  logic [3:0] m;
  logic [4:0] d;
  logic [2:0] d_div3, bpsc_q;
  logic [1:0] d_mod3, m_mod3, j6_off;
  logic       cfg_ok, first_bit;
  logic [2:0] eff_bpsc;
  logic [4:0] bpsc_x3;
  logic [8:0] i_addr, g6, j6, j_addr;

  assign cfg_ok    = (cfg_bpsc == 3'd1) || (cfg_bpsc == 3'd2) || (cfg_bpsc == 3'd4) || (cfg_bpsc == 3'd6);
  assign first_bit = (state == FILL) && (wr_cnt == 9'd0);
  // The first bit of a symbol already needs its own bpsc, before bpsc_q can be loaded.
  assign eff_bpsc  = first_bit ? (cfg_ok ? cfg_bpsc : 3'd1) : bpsc_q;
  assign ib_bpsc   = eff_bpsc;
  assign ib_cap    = {1'b0, eff_bpsc, 5'd0} + {2'b0, eff_bpsc, 4'd0};

  assign in_ready   = (state == FILL) && (wr_cnt != ib_cap);
  assign ib_wr_en   = in_valid && in_ready;
  assign ib_data_in = in_bit;

  assign bpsc_x3 = {2'b0, eff_bpsc} + {1'b0, eff_bpsc, 1'b0};
  assign i_addr  = ({4'd0, bpsc_x3} * {5'd0, m}) + {4'd0, d};

  // bpsc=6 rotation: 3*(6m + d/3) + ((d mod 3) - (m mod 3)) mod 3, from running mod-3 counters
  assign g6     = {3'd0, m, 2'd0} + {4'd0, m, 1'b0} + {6'd0, d_div3};
  assign j6_off = (d_mod3 >= m_mod3) ? (d_mod3 - m_mod3) : (d_mod3 + 2'd3 - m_mod3);
  assign j6     = {g6[7:0], 1'b0} + g6 + {7'd0, j6_off};

  always_comb begin
    j_addr = i_addr;
    case (eff_bpsc)
      3'd4:    j_addr = {i_addr[8:1], i_addr[0] ^ m[0]};
      3'd6:    j_addr = j6;
      default: j_addr = i_addr;
    endcase
  end
  assign ib_wr_addr = j_addr[ADDR_W-1:0];

  assign ib_rd_en   = (state == DRAIN) && (rd_cnt < NSC6) && (!out_valid || out_ready);
  assign ib_rd_addr = rd_cnt;
  assign ib_clear   = (state == CLR);
  assign out_data   = ib_data_out;
  assign out_last   = out_valid && (grp_idx == NSC6 - 6'd1);

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= FILL;
      wr_cnt    <= '0;
      rd_cnt    <= '0;
      grp_idx   <= '0;
      m         <= '0;
      d         <= '0;
      d_div3    <= '0;
      d_mod3    <= '0;
      m_mod3    <= '0;
      bpsc_q    <= 3'd1;
      out_valid <= 1'b0;
      cfg_err   <= 1'b0;
    end else begin
      case (state)
        FILL: begin
          if (ib_wr_en) begin
            wr_cnt <= wr_cnt + 9'd1;
            if (first_bit) begin
              bpsc_q <= eff_bpsc;
              if (!cfg_ok) cfg_err <= 1'b1;
            end
            if (m == 4'd15) begin
              m      <= '0;
              m_mod3 <= '0;
              d      <= d + 5'd1;
              if (d_mod3 == 2'd2) begin
                d_mod3 <= '0;
                d_div3 <= d_div3 + 3'd1;
              end else begin
                d_mod3 <= d_mod3 + 2'd1;
              end
            end else begin
              m      <= m + 4'd1;
              m_mod3 <= (m_mod3 == 2'd2) ? 2'd0 : m_mod3 + 2'd1;
            end
          end
          if ((wr_cnt == ib_cap) && ib_full) state <= DRAIN;
        end
        DRAIN: begin
          if (out_valid && out_ready && out_last) state <= CLR;
        end
        CLR: begin
          wr_cnt <= '0;
          rd_cnt <= '0;
          m      <= '0;
          d      <= '0;
          d_div3 <= '0;
          d_mod3 <= '0;
          m_mod3 <= '0;
          state  <= FILL;
        end
        default: state <= FILL;
      endcase

      if (ib_rd_en) begin
        rd_cnt    <= rd_cnt + 6'd1;
        grp_idx   <= rd_cnt;
        out_valid <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_interleaver_ctrl.sv
// tb/tb_interleaver_ctrl.sv - randomized bench for interleaver_ctrl
// Interleaver buffer modelled here; expectations come from the 802.11a permutation formulas.
module tb_interleaver_ctrl;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [2:0] cfg_bpsc = 3'd1;
  logic       in_valid = 1'b0, in_bit = 1'b0, ib_full, out_ready;
  logic [5:0] ib_data_out;
  logic       in_ready, ib_wr_en, ib_data_in, ib_rd_en, ib_clear, out_valid, out_last, cfg_err;
  logic [8:0] ib_wr_addr, ib_cap;
  logic [5:0] ib_rd_addr, out_data;
  logic [2:0] ib_bpsc;

  always #5 clk = ~clk;

  interleaver_ctrl dut (
    .clk(clk), .reset(reset), .cfg_bpsc(cfg_bpsc), .in_valid(in_valid), .in_bit(in_bit),
    .in_ready(in_ready), .ib_wr_en(ib_wr_en), .ib_wr_addr(ib_wr_addr), .ib_data_in(ib_data_in),
    .ib_rd_en(ib_rd_en), .ib_rd_addr(ib_rd_addr), .ib_cap(ib_cap), .ib_bpsc(ib_bpsc),
    .ib_clear(ib_clear), .ib_full(ib_full), .ib_data_out(ib_data_out), .out_valid(out_valid),
    .out_data(out_data), .out_last(out_last), .out_ready(out_ready), .cfg_err(cfg_err)
  );

  int checks = 0, errors = 0;

  // external buffer: bit j at address j, subcarrier r reads bits r*bpsc .. r*bpsc+bpsc-1 LSB first
  bit mem [0:287];
  int buf_cnt;

  function automatic logic [5:0] rd_group(input int r, input int b);
    logic [5:0] g = '0;
    for (int t = 0; t < b && t < 6; t++)
      if (r * b + t < 288) g[t] = mem[r * b + t];
    return g;
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      buf_cnt <= 0;
      ib_full <= 1'b0;
      ib_data_out <= '0;
    end else begin
      if (ib_clear) begin
        buf_cnt <= 0;
        ib_full <= 1'b0;
      end else if (ib_wr_en) begin
        mem[ib_wr_addr] <= ib_data_in;
        buf_cnt <= buf_cnt + 1;
        ib_full <= (buf_cnt + 1 == int'(ib_cap));
      end
      if (ib_rd_en) ib_data_out <= rd_group(int'(ib_rd_addr), int'(ib_bpsc));
    end
  end

  // sink back-pressure
  int rdy_mode = 0, rdy_ph = 0;
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        0: out_ready = 1'b1;
        1: out_ready = 1'($urandom % 2);
        default: begin
          out_ready = (rdy_ph == 0) || (rdy_ph == 3);
          rdy_ph = (rdy_ph + 1) % 4;
        end
      endcase
    end
  end

  // observation, mid-cycle
  int cyc = 0;
  logic [5:0] grp_q[$];
  bit last_q[$];
  int acc_cyc_q[$], wr_addr_q[$], wr_bpsc_q[$], wr_cap_q[$];
  int clr_cnt = 0, excl_err = 0, stall_err = 0, rdy_err = 0, clr_len_err = 0;
  bit prev_stall = 0, prev_clr = 0;
  logic [5:0] prev_data;

  always @(negedge clk) begin
    cyc++;
    if (reset) begin
      prev_stall = 0;
      prev_clr = 0;
    end else begin
      if (ib_wr_en) begin
        wr_addr_q.push_back(int'(ib_wr_addr));
        wr_bpsc_q.push_back(int'(ib_bpsc));
        wr_cap_q.push_back(int'(ib_cap));
      end
      if (out_valid && out_ready) begin
        grp_q.push_back(out_data);
        last_q.push_back(out_last);
        acc_cyc_q.push_back(cyc);
      end
      if (ib_clear) clr_cnt++;
      if (ib_clear && prev_clr) clr_len_err++;
      if (int'(ib_wr_en) + int'(ib_rd_en) + int'(ib_clear) > 1) excl_err++;
      if (in_ready && (ib_clear || ib_rd_en || out_valid)) rdy_err++;
      if (prev_stall && (!out_valid || out_data !== prev_data)) stall_err++;
      if (out_valid && !out_ready && ib_rd_en) stall_err++;
      prev_stall = out_valid && !out_ready;
      prev_data = out_data;
      prev_clr = ib_clear;
    end
  end

  // reference model
  bit stim_bit[$];
  logic [2:0] stim_cfg[$];
  logic [5:0] exp_grp[$];
  int exp_j[$], exp_eff[$];

  function automatic int jref(input int k, input int b);
    int n = 48 * b;
    int s = (b / 2 > 1) ? b / 2 : 1;
    int i = (n / 16) * (k % 16) + k / 16;
    return s * (i / s) + (i + n - (16 * i) / n) % s;
  endfunction

  task automatic push_symbol(input logic [2:0] cfg, input int eff);
    bit byj [0:287];
    int n = 48 * eff;
    for (int k = 0; k < n; k++) begin
      bit b = 1'($urandom % 2);
      stim_bit.push_back(b);
      stim_cfg.push_back(cfg);
      exp_j.push_back(jref(k, eff));
      exp_eff.push_back(eff);
      byj[jref(k, eff)] = b;
    end
    for (int r = 0; r < 48; r++) begin
      logic [5:0] g = '0;
      for (int t = 0; t < eff; t++) g[t] = byj[r * eff + t];
      exp_grp.push_back(g);
    end
  endtask

  task automatic clear_logs();
    stim_bit.delete(); stim_cfg.delete(); exp_grp.delete(); exp_j.delete(); exp_eff.delete();
    grp_q.delete(); last_q.delete(); acc_cyc_q.delete();
    wr_addr_q.delete(); wr_bpsc_q.delete(); wr_cap_q.delete();
    clr_cnt = 0; stall_err = 0; rdy_err = 0; clr_len_err = 0;
  endtask

  task automatic do_reset();
    reset = 1'b1; in_valid = 1'b0; in_bit = 1'b0; cfg_bpsc = 3'd1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    clear_logs();
  endtask

  task automatic feed(input int max_acc);
    int acc = 0;
    int guard = 0;
    while (stim_bit.size() > 0 && acc < max_acc && guard < 20000) begin
      in_valid = 1'b1;
      in_bit = stim_bit[0];
      cfg_bpsc = stim_cfg[0];
      @(negedge clk);
      if (in_ready) begin
        void'(stim_bit.pop_front());
        void'(stim_cfg.pop_front());
        acc++;
      end
      @(posedge clk); #1;
      guard++;
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_clears(input int target, output bit ok);
    int guard = 0;
    while (clr_cnt < target && guard < 3000) begin
      @(posedge clk); #1;
      guard++;
    end
    ok = (clr_cnt >= target);
  endtask

  task automatic score(output int bg, output int ba, output int bl, output int bm);
    bg = 0; ba = 0; bl = 0; bm = 0;
    if (grp_q.size() != exp_grp.size()) bg++;
    for (int r = 0; r < grp_q.size() && r < exp_grp.size(); r++) begin
      if (grp_q[r] !== exp_grp[r]) bg++;
      if (last_q[r] !== ((r % 48) == 47)) bl++;
    end
    if (wr_addr_q.size() != exp_j.size()) ba++;
    for (int w = 0; w < wr_addr_q.size() && w < exp_j.size(); w++) begin
      if (wr_addr_q[w] != exp_j[w]) ba++;
      if (wr_bpsc_q[w] != exp_eff[w] || wr_cap_q[w] != 48 * exp_eff[w]) bm++;
    end
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    checks++;
    if ({in_ready, ib_wr_en, ib_rd_en, ib_clear, out_valid, out_last, cfg_err} !== 7'b1000000) begin
      $display("FAIL reset_outputs got=%b exp=1000000",
               {in_ready, ib_wr_en, ib_rd_en, ib_clear, out_valid, out_last, cfg_err});
      errors++;
    end
    checks++;
    if (ib_cap !== 9'd48) begin $display("FAIL reset_cap got=%0d exp=48", ib_cap); errors++; end
    @(posedge clk); #1;
  endtask

  task automatic test_bpsc1();
    bit ok; int bg, ba, bl, bm, span;
    do_reset();
    rdy_mode = 0;
    push_symbol(3'd1, 1);
    feed(100000);
    wait_clears(1, ok);
    score(bg, ba, bl, bm);
    checks++; if (!ok) begin $display("FAIL b1_timeout got=%0d exp=1 clears", clr_cnt); errors++; end
    checks++; if (bg != 0) begin $display("FAIL b1_groups got=%0d bad exp=0", bg); errors++; end
    checks++; if (ba != 0 || bm != 0) begin $display("FAIL b1_addr got=%0d/%0d bad exp=0", ba, bm); errors++; end
    checks++; if (bl != 0) begin $display("FAIL b1_last got=%0d bad exp=0", bl); errors++; end
    checks++;
    if (wr_addr_q.size() < 17 || wr_addr_q[1] != 3 || wr_addr_q[16] != 1) begin
      $display("FAIL b1_k1_k16 got=%0d,%0d exp=3,1",
               wr_addr_q.size() > 1 ? wr_addr_q[1] : -1, wr_addr_q.size() > 16 ? wr_addr_q[16] : -1);
      errors++;
    end
    span = (acc_cyc_q.size() == 48) ? acc_cyc_q[47] - acc_cyc_q[0] : -1;
    checks++; if (span != 47) begin $display("FAIL b1_b2b_span got=%0d exp=47", span); errors++; end
  endtask

  task automatic test_bpsc6();
    bit ok; bit seen [0:287]; int dup = 0; int bg, ba, bl, bm;
    do_reset();
    rdy_mode = 1;
    push_symbol(3'd6, 6);
    feed(100000);
    wait_clears(1, ok);
    score(bg, ba, bl, bm);
    foreach (wr_addr_q[w]) begin
      if (wr_addr_q[w] > 287 || seen[wr_addr_q[w]]) dup++;
      else seen[wr_addr_q[w]] = 1'b1;
    end
    checks++; if (!ok) begin $display("FAIL b6_timeout got=%0d exp=1 clears", clr_cnt); errors++; end
    checks++;
    if (dup != 0 || wr_addr_q.size() != 288) begin
      $display("FAIL b6_perm got=%0d dup %0d writes exp=0 dup 288 writes", dup, wr_addr_q.size()); errors++;
    end
    checks++;
    if (wr_addr_q.size() < 2 || wr_addr_q[1] != 20) begin
      $display("FAIL b6_k1 got=%0d exp=20", wr_addr_q.size() > 1 ? wr_addr_q[1] : -1); errors++;
    end
    checks++; if (ba != 0 || bm != 0) begin $display("FAIL b6_addr got=%0d/%0d bad exp=0", ba, bm); errors++; end
    checks++; if (bg != 0 || bl != 0) begin $display("FAIL b6_groups got=%0d/%0d bad exp=0", bg, bl); errors++; end
  endtask

  task automatic test_bpsc4();
    bit ok; int bg, ba, bl, bm;
    do_reset();
    rdy_mode = 1;
    push_symbol(3'd4, 4);
    feed(100000);
    wait_clears(1, ok);
    score(bg, ba, bl, bm);
    checks++; if (!ok) begin $display("FAIL b4_timeout got=%0d exp=1 clears", clr_cnt); errors++; end
    checks++;
    if (wr_addr_q.size() < 3 || wr_addr_q[1] != 13 || wr_addr_q[2] != 24) begin
      $display("FAIL b4_k1_k2 got=%0d,%0d exp=13,24",
               wr_addr_q.size() > 1 ? wr_addr_q[1] : -1, wr_addr_q.size() > 2 ? wr_addr_q[2] : -1);
      errors++;
    end
    checks++; if (bg != 0 || bl != 0) begin $display("FAIL b4_groups got=%0d/%0d bad exp=0", bg, bl); errors++; end
    checks++; if (ba != 0 || bm != 0) begin $display("FAIL b4_addr got=%0d/%0d bad exp=0", ba, bm); errors++; end
  endtask

  task automatic test_stall();
    bit ok; int bg, ba, bl, bm;
    do_reset();
    rdy_ph = 0;
    rdy_mode = 2;
    push_symbol(3'd2, 2);
    feed(100000);
    wait_clears(1, ok);
    score(bg, ba, bl, bm);
    rdy_mode = 0;
    checks++; if (!ok) begin $display("FAIL stall_timeout got=%0d exp=1 clears", clr_cnt); errors++; end
    checks++; if (stall_err != 0) begin $display("FAIL stall_stable got=%0d exp=0", stall_err); errors++; end
    checks++; if (grp_q.size() != 48 || bg != 0) begin $display("FAIL stall_groups got=%0d/%0d exp=48/0", grp_q.size(), bg); errors++; end
    checks++; if (bl != 0) begin $display("FAIL stall_last got=%0d bad exp=0", bl); errors++; end
  endtask

  task automatic test_back_to_back();
    bit ok; int bg, ba, bl, bm;
    do_reset();
    rdy_mode = 0;
    push_symbol(3'd2, 2);
    push_symbol(3'd6, 6);
    feed(100000);
    wait_clears(2, ok);
    score(bg, ba, bl, bm);
    checks++; if (!ok || clr_cnt != 2) begin $display("FAIL b2b_clears got=%0d exp=2", clr_cnt); errors++; end
    checks++; if (clr_len_err != 0) begin $display("FAIL b2b_clear_pulse got=%0d exp=0", clr_len_err); errors++; end
    checks++; if (rdy_err != 0) begin $display("FAIL b2b_in_ready got=%0d exp=0", rdy_err); errors++; end
    checks++;
    if (wr_cap_q.size() < 97 || wr_cap_q[96] != 288) begin
      $display("FAIL b2b_cap2 got=%0d exp=288", wr_cap_q.size() > 96 ? wr_cap_q[96] : -1); errors++;
    end
    checks++; if (bg != 0 || bl != 0 || ba != 0 || bm != 0) begin
      $display("FAIL b2b_data got=%0d/%0d/%0d/%0d bad exp=0", bg, bl, ba, bm); errors++;
    end
    checks++; if (excl_err != 0) begin $display("FAIL exclusive_en got=%0d exp=0", excl_err); errors++; end
  endtask

  task automatic test_reset_mid();
    bit ok; int bg, ba, bl, bm;
    do_reset();
    rdy_mode = 1;
    push_symbol(3'd4, 4);
    feed(100);
    do_reset();
    push_symbol(3'd1, 1);
    feed(100000);
    wait_clears(1, ok);
    score(bg, ba, bl, bm);
    checks++; if (!ok) begin $display("FAIL rst_mid_timeout got=%0d exp=1 clears", clr_cnt); errors++; end
    checks++; if (bg != 0 || bl != 0 || ba != 0 || bm != 0) begin
      $display("FAIL rst_mid_data got=%0d/%0d/%0d/%0d bad exp=0", bg, bl, ba, bm); errors++;
    end
    checks++; if (cfg_err !== 1'b0) begin $display("FAIL cfg_err_clean got=%b exp=0", cfg_err); errors++; end
    clear_logs();
    push_symbol(3'd3, 1);
    feed(100000);
    wait_clears(1, ok);
    score(bg, ba, bl, bm);
    checks++; if (cfg_err !== 1'b1) begin $display("FAIL cfg_err_set got=%b exp=1", cfg_err); errors++; end
    checks++; if (!ok || bg != 0 || bl != 0 || ba != 0 || bm != 0) begin
      $display("FAIL illegal_as_b1 got=%0d/%0d/%0d/%0d/%0d bad exp=1/0/0/0/0", ok, bg, bl, ba, bm); errors++;
    end
  endtask

  initial begin
    test_reset();
    test_bpsc1();
    test_bpsc6();
    test_bpsc4();
    test_stall();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
endmodule
